fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one fifo write port among N_REQ valid/ready producer channels.

---
 rtl/fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter merging N_REQ valid/ready producers
//            onto a single fifo write port. Optional source tag on the write
//            data is enabled by defining FIFO_WR_ARB_TAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 24,
    parameter int MAX_BURST = 4,
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int TW = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
`else
    localparam int TW = 0
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_valid,
    input  logic [N_REQ*DW-1:0]   i_data,
    output logic [N_REQ-1:0]      o_ready,
    output logic                  o_wr,
    output logic [DW+TW-1:0]      o_wdata,
    input  logic                  i_wfull,
    output logic [N_REQ-1:0]      o_grant
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] c_last_idx = IW'(N_REQ - 1);
    localparam logic [CW-1:0] c_max_cnt  = CW'(MAX_BURST);
    localparam logic [IW:0]   c_n_req    = (IW+1)'(N_REQ);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      w_gidx_nxt;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_ptr_nxt;
    logic [IW-1:0]      w_gidx_inc;
    logic [IW-1:0]      w_base;
    logic [IW-1:0]      w_pick;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_xfer;
    logic               w_burst_end;
    logic               w_found;
    logic [2*N_REQ-1:0] w_rot;
    logic [IW:0]        w_sum;
    logic [DW-1:0]      w_gdata;
    logic [DW+TW-1:0]   w_wdata_nxt;
    logic               r_wr;
    logic [DW+TW-1:0]   r_wdata;

    // ------------------------------------------------------------------
    // Granted channel datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_gdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gidx == IW'(k)) begin
                w_gdata = i_data[k*DW +: DW];
            end
        end
    end

`ifdef FIFO_WR_ARB_TAG_EN
    assign w_wdata_nxt = {TW'(r_gidx), w_gdata};
`else
    assign w_wdata_nxt = w_gdata;
`endif

    assign w_xfer     = (r_state == S_BURST) && i_valid[r_gidx] && !i_wfull;
    assign o_ready    = ((r_state == S_BURST) && !i_wfull) ? r_grant : '0;
    assign w_gidx_inc = (r_gidx == c_last_idx) ? '0 : r_gidx + IW'(1);

    // Search origin: the stored pointer when idle, otherwise one past the
    // current grant so the outgoing channel is considered last.
    assign w_base = (r_state == S_IDLE) ? r_ptr : w_gidx_inc;
    assign w_rot  = {i_valid, i_valid} >> w_base;

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        w_pick  = '0;
        // Walk downward so the lowest rotated position is the one kept.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, w_base} + (IW+1)'(k);
            end
        end
        if (w_sum >= c_n_req) begin
            w_pick = IW'(w_sum - c_n_req);
        end else begin
            w_pick = w_sum[IW-1:0];
        end
    end

    assign w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_burst_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BURST;
                    w_gidx_nxt  = w_pick;
                    w_grant_nxt = w_pick_oh;
                    w_cnt_nxt   = '0;
                end
            end
            S_BURST: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                // A full fifo freezes the burst; a producer gap only counts
                // when the fifo could have accepted the word.
                w_burst_end = (w_xfer && (r_cnt + CW'(1) == c_max_cnt)) ||
                              (!i_valid[r_gidx] && !i_wfull);
                if (w_burst_end) begin
                    w_ptr_nxt = w_gidx_inc;
                    w_cnt_nxt = '0;
                    if (w_found) begin
                        w_gidx_nxt  = w_pick;
                        w_grant_nxt = w_pick_oh;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gidx_nxt  = '0;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gidx_nxt  = '0;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wr    <= w_xfer;
            if (w_xfer) begin
                r_wdata <= w_wdata_nxt;
            end
        end
    end

    assign o_wr    = r_wr;
    assign o_wdata = r_wdata;
    assign o_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed self-checking bench for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DW        = 24;
    localparam int MAX_BURST = 4;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int TW = 2;
`else
    localparam int TW = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_REQ-1:0]    i_valid = '0;
    logic [N_REQ*DW-1:0] i_data = '0;
    logic [N_REQ-1:0]    o_ready;
    logic                o_wr;
    logic [DW+TW-1:0]    o_wdata;
    logic                i_wfull = 1'b0;
    logic [N_REQ-1:0]    o_grant;

    int               checks   = 0;
    int               failures = 0;
    int               left[N_REQ];
    int               seq[N_REQ];
    logic [DW-1:0]    base_data[N_REQ];
    logic [N_REQ-1:0] acc = '0;
    logic [DW+TW-1:0] wq[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_wr    (o_wr),
        .o_wdata (o_wdata),
        .i_wfull (i_wfull),
        .o_grant (o_grant)
    );

    // Handshakes are judged on the settled values half a cycle before the edge.
    always @(negedge clk) acc = i_valid & o_ready;

    function automatic logic [DW+TW-1:0] exp_word(input int ch, input int s);
        logic [DW-1:0] d;
        d = {4'hA, 4'(ch), 16'(s)};
`ifdef FIFO_WR_ARB_TAG_EN
        return {2'(ch), d};
`else
        return d;
`endif
    endfunction

    task automatic drive();
        for (int k = 0; k < N_REQ; k++) begin
            i_valid[k]          = (left[k] > 0);
            i_data[k*DW +: DW]  = base_data[k] + DW'(seq[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N_REQ; k++) begin
            if (acc[k]) begin
                left[k] = left[k] - 1;
                seq[k]  = seq[k] + 1;
            end
        end
        drive();
        if (o_wr === 1'b1) wq.push_back(o_wdata);
    endtask

    task automatic clear_producers();
        for (int k = 0; k < N_REQ; k++) begin
            left[k]      = 0;
            seq[k]       = 0;
            base_data[k] = {4'hA, 4'(k), 16'h0};
        end
        i_wfull = 1'b0;
        wq.delete();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        clear_producers();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW+TW-1:0] e;
        rst = 1'b0;
        clear_producers();
        step();
        checks++; if (o_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", o_wr); end
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", o_grant); end
        checks++; if (o_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", o_ready); end
        checks++; if (o_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", o_wdata); end
        rst = 1'b1;
        left[2] = 8;
        drive();
        step();
        checks++; if (o_grant !== 4'b0100) begin failures++; $display("FAIL reset_pre_grant got=%b exp=0100", o_grant); end
        for (int s = 2; s <= 6; s++) step();
        checks++; if (o_wr !== 1'b1 || o_grant !== 4'b0100) begin
            failures++; $display("FAIL reset_midburst_setup got wr=%b grant=%b exp wr=1 grant=0100", o_wr, o_grant);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (o_wr !== 1'b0) begin failures++; $display("FAIL reset_async_wr got=%b exp=0", o_wr); end
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL reset_async_grant got=%b exp=0000", o_grant); end
        checks++; if (o_ready !== 4'b0000) begin failures++; $display("FAIL reset_async_ready got=%b exp=0000", o_ready); end
        step();
        clear_producers();
        rst = 1'b1;
        for (int k = 0; k < N_REQ; k++) left[k] = 4;
        drive();
        step();
        checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", o_grant); end
        checks++; if (o_wr !== 1'b0) begin failures++; $display("FAIL reset_no_partial got=%b exp=0", o_wr); end
        step();
        e = exp_word(0, 0);
        checks++; if (o_wr !== 1'b1 || o_wdata !== e) begin
            failures++; $display("FAIL reset_first_word got wr=%b data=%h exp wr=1 data=%h", o_wr, o_wdata, e);
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] gl[22];
        logic [DW+TW-1:0] e;
        logic [DW+TW-1:0] got;
        do_reset();
        for (int k = 0; k < N_REQ; k++) left[k] = 8;
        drive();
        for (int s = 1; s <= 21; s++) begin
            step();
            gl[s] = o_grant;
            if (s >= 2) begin
                checks++; if (o_wr !== 1'b1) begin failures++; $display("FAIL rr_wr_gap step=%0d got=%b exp=1", s, o_wr); end
            end
        end
        checks++; if (gl[1]  !== 4'b0001) begin failures++; $display("FAIL rr_grant_s1 got=%b exp=0001", gl[1]); end
        checks++; if (gl[4]  !== 4'b0001) begin failures++; $display("FAIL rr_grant_s4 got=%b exp=0001", gl[4]); end
        checks++; if (gl[5]  !== 4'b0010) begin failures++; $display("FAIL rr_grant_s5 got=%b exp=0010", gl[5]); end
        checks++; if (gl[9]  !== 4'b0100) begin failures++; $display("FAIL rr_grant_s9 got=%b exp=0100", gl[9]); end
        checks++; if (gl[13] !== 4'b1000) begin failures++; $display("FAIL rr_grant_s13 got=%b exp=1000", gl[13]); end
        checks++; if (gl[17] !== 4'b0001) begin failures++; $display("FAIL rr_grant_s17 got=%b exp=0001", gl[17]); end
        checks++; if (gl[21] !== 4'b0010) begin failures++; $display("FAIL rr_grant_s21 got=%b exp=0010", gl[21]); end
        checks++; if (wq.size() != 20) begin failures++; $display("FAIL rr_count got=%0d exp=20", wq.size()); end
        for (int i = 0; i < 20; i++) begin
            e   = exp_word((i / 4) % 4, (i / 16) * 4 + (i % 4));
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++; if (got !== e) begin failures++; $display("FAIL rr_word idx=%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW+TW-1:0] e;
        logic [DW+TW-1:0] got;
        do_reset();
        left[2] = 10;
        drive();
        step();
        checks++; if (o_grant !== 4'b0100) begin failures++; $display("FAIL b2b_grant_s1 got=%b exp=0100", o_grant); end
        for (int s = 2; s <= 11; s++) begin
            step();
            checks++; if (o_wr !== 1'b1 || o_grant !== 4'b0100) begin
                failures++; $display("FAIL b2b_stream step=%0d got wr=%b grant=%b exp wr=1 grant=0100", s, o_wr, o_grant);
            end
        end
        step();
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL b2b_idle_grant got=%b exp=0000", o_grant); end
        checks++; if (o_wr !== 1'b0) begin failures++; $display("FAIL b2b_idle_wr got=%b exp=0", o_wr); end
        checks++; if (wq.size() != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", wq.size()); end
        for (int i = 0; i < 10; i++) begin
            e   = exp_word(2, i);
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++; if (got !== e) begin failures++; $display("FAIL b2b_word idx=%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_wfull_stall();
        logic [DW+TW-1:0] e;
        logic [DW+TW-1:0] got;
        do_reset();
        left[1] = 4;
        drive();
        step();
        checks++; if (o_grant !== 4'b0010) begin failures++; $display("FAIL stall_grant_s1 got=%b exp=0010", o_grant); end
        step();
        checks++; if (o_wr !== 1'b1) begin failures++; $display("FAIL stall_first_wr got=%b exp=1", o_wr); end
        i_wfull = 1'b1;
        for (int s = 3; s <= 7; s++) begin
            step();
            checks++; if (o_ready !== 4'b0000 || o_wr !== 1'b0 || o_grant !== 4'b0010) begin
                failures++; $display("FAIL stall_hold step=%0d got ready=%b wr=%b grant=%b exp ready=0000 wr=0 grant=0010",
                                     s, o_ready, o_wr, o_grant);
            end
        end
        i_wfull = 1'b0;
        for (int s = 8; s <= 10; s++) begin
            step();
            checks++; if (o_wr !== 1'b1) begin failures++; $display("FAIL stall_resume step=%0d got=%b exp=1", s, o_wr); end
        end
        step();
        checks++; if (o_wr !== 1'b0 || o_grant !== 4'b0000) begin
            failures++; $display("FAIL stall_end got wr=%b grant=%b exp wr=0 grant=0000", o_wr, o_grant);
        end
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            e   = exp_word(1, i);
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++; if (got !== e) begin failures++; $display("FAIL stall_word idx=%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_gap();
        logic [DW+TW-1:0] e;
        logic [DW+TW-1:0] got;
        do_reset();
        left[3] = 1;
        drive();
        step();
        checks++; if (o_grant !== 4'b1000) begin failures++; $display("FAIL gap_grant_s1 got=%b exp=1000", o_grant); end
        left[0] = 2;
        drive();
        step();
        checks++; if (o_wr !== 1'b1 || o_grant !== 4'b1000) begin
            failures++; $display("FAIL gap_s2 got wr=%b grant=%b exp wr=1 grant=1000", o_wr, o_grant);
        end
        step();
        checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL gap_wrap_grant got=%b exp=0001", o_grant); end
        step();
        step();
        step();
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL gap_idle got=%b exp=0000", o_grant); end
        left[0] = 1;
        left[1] = 1;
        drive();
        step();
        checks++; if (o_grant !== 4'b0010) begin failures++; $display("FAIL gap_ptr_grant got=%b exp=0010", o_grant); end
        checks++; if (wq.size() != 3) begin failures++; $display("FAIL gap_count got=%0d exp=3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            e   = (i == 0) ? exp_word(3, 0) : exp_word(0, i - 1);
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++; if (got !== e) begin failures++; $display("FAIL gap_word idx=%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_tag();
        logic [DW+TW-1:0] e;
`ifdef FIFO_WR_ARB_TAG_EN
        e = {2'd1, 24'hABCDEF};
`else
        e = 24'hABCDEF;
`endif
        do_reset();
        base_data[1] = 24'hABCDEF;
        left[1]      = 1;
        drive();
        step();
        checks++; if (o_grant !== 4'b0010) begin failures++; $display("FAIL tag_grant got=%b exp=0010", o_grant); end
        step();
        checks++; if (o_wr !== 1'b1 || o_wdata !== e) begin
            failures++; $display("FAIL tag_word got wr=%b data=%h exp wr=1 data=%h", o_wr, o_wdata, e);
        end
        step();
        checks++; if (o_wr !== 1'b0 || o_wdata !== e) begin
            failures++; $display("FAIL tag_hold got wr=%b data=%h exp wr=0 data=%h", o_wr, o_wdata, e);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_wfull_stall();
        test_gap();
        test_tag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
